// File: rtl/ti_load_ctrl_pkg.sv
// Shared types and address helpers for the load datapath.
// Pure declarations: no state, no latency.
package ti_load_pkg;

  typedef enum logic {DST_RAM, DST_SPCH} dest_t;
  typedef enum logic {IDLE, SDR_WAIT} state_t;

  localparam logic [7:0] IDX_C = 8'd1;
  localparam logic [7:0] IDX_D = 8'd2;
  localparam logic [7:0] IDX_G = 8'd3;

  localparam logic [16:0] D_OFFSET_DEF = 17'h01000;
  localparam logic [16:0] G_OFFSET_DEF = 17'h0B000;

  function automatic dest_t decode_dest(input logic [24:0] addr);
    return (addr[24:18] != 7'd0) ? DST_SPCH : DST_RAM;
  endfunction

  // Only the low two index bits select the offset; the low address bit is
  // inverted because the 16-bit RAM stores bytes in the opposite order.
  function automatic logic [17:0] ram_byte_addr(input logic [24:0] addr,
                                                input logic [7:0]  index,
                                                input logic [16:0] d_off,
                                                input logic [16:0] g_off);
    logic [16:0] off;
    case ({6'd0, index[1:0]})
      IDX_C:   off = 17'd0;
      IDX_D:   off = d_off;
      IDX_G:   off = g_off;
      default: off = 17'd0;
    endcase
    return {addr[17:1] + off, ~addr[0]};
  endfunction

endpackage

// File: rtl/ti_load_ctrl_if.sv
// HPS ioctl download stream: byte strobe with address/data, throttled by wait.
// Source must hold off strobes while dl_wait_o is high.
interface ti_load_ctrl_if;

  logic        dl_active_i;
  logic [7:0]  dl_index_i;
  logic        dl_wr_i;
  logic [24:0] dl_addr_i;
  logic [7:0]  dl_data_i;
  logic        dl_wait_o;

  modport master (
    output dl_active_i, dl_index_i, dl_wr_i, dl_addr_i, dl_data_i,
    input  dl_wait_o
  );

  modport slave (
    input  dl_active_i, dl_index_i, dl_wr_i, dl_addr_i, dl_data_i,
    output dl_wait_o
  );

endinterface

// File: rtl/ti_load_ctrl_reset_stretch.sv
// Console reset sequencer: init reset, reset while loading/requested, then a
// HOLD_CYCLES stretch; outputs registered, one cycle after the inputs.
module reset_stretch #(
  parameter int HOLD_CYCLES = 255,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dl_active,
  input  logic dl_start,
  input  logic rst_req,
  input  logic busy,
  output logic sys_reset,
  output logic loading
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             init_q;
  logic             init_d;
  logic             reload;
  logic             sys_reset_q;
  logic             loading_q;

  always_comb begin
    reload = dl_active | rst_req | busy;
    init_d = init_q & ~dl_start;
    cnt_d  = cnt_q;
    if (reload) begin
      cnt_d = HOLD_LD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Outputs are computed from next-state so the deassert lands exactly
  // HOLD_CYCLES+1 cycles after the last reload cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      init_q      <= 1'b1;
      sys_reset_q <= 1'b1;
      loading_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      init_q      <= init_d;
      sys_reset_q <= init_d | dl_active | rst_req | (cnt_d != '0);
      loading_q   <= dl_active | (cnt_d != '0);
    end
  end

  assign sys_reset = sys_reset_q;
  assign loading   = loading_q;

endmodule

// File: rtl/ti_load_ctrl.sv
// Routes download bytes to CPU RAM / speech ROM and mirrors each to SDRAM.
// Write pulses one cycle after the strobe; dl_wait_o holds until SDRAM ack.
module ti_load_ctrl
  import ti_load_pkg::*;
#(
  parameter int          HOLD_CYCLES = 255,
  parameter int          CNT_W       = 8,
  parameter logic [16:0] D_OFFSET    = D_OFFSET_DEF,
  parameter logic [16:0] G_OFFSET    = G_OFFSET_DEF
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  ti_load_ctrl_if.slave dl,
  input  logic          rst_req_i,
  output logic          ram_we_o,
  output logic [17:0]   ram_addr_o,
  output logic [7:0]    ram_data_o,
  output logic          spch_we_o,
  output logic [14:0]   spch_addr_o,
  output logic [7:0]    spch_data_o,
  output logic          sdr_req_o,
  output logic [24:0]   sdr_addr_o,
  output logic [7:0]    sdr_data_o,
  input  logic          sdr_ack_i,
  output logic          sys_reset_o,
  output logic          loading_o,
  output logic          rom_mask_o,
  output logic          ovf_o
);

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic        drop;
  dest_t       dest;
  logic        busy;
  logic        act_q;
  logic        dl_start;

  logic        ram_we_q;
  logic [17:0] ram_addr_q;
  logic [7:0]  ram_data_q;
  logic        spch_we_q;
  logic [14:0] spch_addr_q;
  logic [7:0]  spch_data_q;
  logic [24:0] sdr_addr_q;
  logic [7:0]  sdr_data_q;
  logic        rom_mask_q;
  logic        ovf_q;

  assign dest     = decode_dest(dl.dl_addr_i);
  assign busy     = (state_q == SDR_WAIT);
  assign dl_start = dl.dl_active_i & ~act_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dl.dl_wr_i) begin
          accept  = 1'b1;
          state_d = SDR_WAIT;
        end
      end
      SDR_WAIT: begin
        drop = dl.dl_wr_i;
        if (sdr_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      act_q       <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      spch_we_q   <= 1'b0;
      spch_addr_q <= '0;
      spch_data_q <= '0;
      sdr_addr_q  <= '0;
      sdr_data_q  <= '0;
      rom_mask_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= dl.dl_active_i;
      ram_we_q  <= accept & (dest == DST_RAM);
      spch_we_q <= accept & (dest == DST_SPCH);
      if (accept && dest == DST_RAM) begin
        ram_addr_q <= ram_byte_addr(dl.dl_addr_i, dl.dl_index_i, D_OFFSET, G_OFFSET);
        ram_data_q <= dl.dl_data_i;
      end
      if (accept && dest == DST_SPCH) begin
        spch_addr_q <= dl.dl_addr_i[14:0];
        spch_data_q <= dl.dl_data_i;
      end
      // SDRAM mirror takes every accepted byte at its raw file address.
      if (accept) begin
        sdr_addr_q <= dl.dl_addr_i;
        sdr_data_q <= dl.dl_data_i;
      end
      if (dl_start) begin
        rom_mask_q <= ~dl.dl_index_i[0];
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  reset_stretch #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_reset_stretch (
    .clk       (clk_i),
    .rst_n     (reset_n_i),
    .dl_active (dl.dl_active_i),
    .dl_start  (dl_start),
    .rst_req   (rst_req_i),
    .busy      (busy),
    .sys_reset (sys_reset_o),
    .loading   (loading_o)
  );

  assign dl.dl_wait_o = busy;
  assign sdr_req_o    = busy;
  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_data_o   = ram_data_q;
  assign spch_we_o    = spch_we_q;
  assign spch_addr_o  = spch_addr_q;
  assign spch_data_o  = spch_data_q;
  assign sdr_addr_o   = sdr_addr_q;
  assign sdr_data_o   = sdr_data_q;
  assign rom_mask_o   = rom_mask_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_ti_load_ctrl.sv
// Directed stimulus for ti_load_ctrl with a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_ti_load_ctrl;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ti_load_ctrl_if dl();

  logic        rst_req = 1'b0;
  logic        sdr_ack = 1'b0;
  logic        ram_we;
  logic [17:0] ram_addr;
  logic [7:0]  ram_data;
  logic        spch_we;
  logic [14:0] spch_addr;
  logic [7:0]  spch_data;
  logic        sdr_req;
  logic [24:0] sdr_addr;
  logic [7:0]  sdr_data;
  logic        sys_reset;
  logic        loading;
  logic        rom_mask;
  logic        ovf;

  ti_load_ctrl #(
    .HOLD_CYCLES (HOLD),
    .CNT_W       (8)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .dl          (dl),
    .rst_req_i   (rst_req),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_data_o  (ram_data),
    .spch_we_o   (spch_we),
    .spch_addr_o (spch_addr),
    .spch_data_o (spch_data),
    .sdr_req_o   (sdr_req),
    .sdr_addr_o  (sdr_addr),
    .sdr_data_o  (sdr_data),
    .sdr_ack_i   (sdr_ack),
    .sys_reset_o (sys_reset),
    .loading_o   (loading),
    .rom_mask_o  (rom_mask),
    .ovf_o       (ovf)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit done   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          p;
  int          p_reload;
  bit          have_rl, m_out, m_ovf, m_mask, m_init, m_act, m_ram_we, m_spch_we;
  bit          m_old, m_rl, mdl_ok = 1'b0, m_el;
  logic [17:0] m_ram_addr;
  logic [7:0]  m_ram_data, m_spch_data, m_sdr_data;
  logic [14:0] m_spch_addr;
  logic [24:0] m_sdr_addr;

  function automatic logic [17:0] exp_ram(input logic [24:0] a, input logic [7:0] idx);
    int off;
    int word;
    off  = (idx[1] == 1'b0) ? 0 : (idx[0] ? 32'h0B000 : 32'h01000);
    word = (int'(a[17:1]) + off) % (1 << 17);
    return {word[16:0], ~a[0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p = 0; p_reload = 0; have_rl = 0; m_out = 0; m_ovf = 0; m_mask = 0;
      m_init = 1; m_act = 0; m_ram_we = 0; m_spch_we = 0;
      m_ram_addr = '0; m_ram_data = '0; m_spch_addr = '0; m_spch_data = '0;
      m_sdr_addr = '0; m_sdr_data = '0;
      mdl_ok = 1'b1;
    end else begin
      p     = p + 1;
      m_old = m_out;
      m_rl  = dl.dl_active_i || rst_req || m_old;
      if (m_rl) begin have_rl = 1; p_reload = p; end
      if (dl.dl_active_i && !m_act) begin m_init = 0; m_mask = ~dl.dl_index_i[0]; end
      m_act     = dl.dl_active_i;
      m_ram_we  = 0;
      m_spch_we = 0;
      if (dl.dl_wr_i && m_old) m_ovf = 1;
      if (dl.dl_wr_i && !m_old) begin
        m_out      = 1;
        m_sdr_addr = dl.dl_addr_i;
        m_sdr_data = dl.dl_data_i;
        if (dl.dl_addr_i[24:18] != 0) begin
          m_spch_we   = 1;
          m_spch_addr = dl.dl_addr_i[14:0];
          m_spch_data = dl.dl_data_i;
        end else begin
          m_ram_we   = 1;
          m_ram_addr = exp_ram(dl.dl_addr_i, dl.dl_index_i);
          m_ram_data = dl.dl_data_i;
        end
      end else if (m_old && sdr_ack) begin
        m_out = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_ok && !done) begin
      m_el = have_rl && ((p - p_reload) < HOLD);
      chk("m_sys_reset", 32'(sys_reset), 32'(m_init || m_el));
      chk("m_loading",   32'(loading),   32'(m_el));
      chk("m_ram_we",    32'(ram_we),    32'(m_ram_we));
      chk("m_spch_we",   32'(spch_we),   32'(m_spch_we));
      chk("m_sdr_req",   32'(sdr_req),   32'(m_out));
      chk("m_dl_wait",   32'(dl.dl_wait_o), 32'(m_out));
      chk("m_ovf",       32'(ovf),       32'(m_ovf));
      chk("m_rom_mask",  32'(rom_mask),  32'(m_mask));
      if (m_ram_we) begin
        chk("m_ram_addr", 32'(ram_addr), 32'(m_ram_addr));
        chk("m_ram_data", 32'(ram_data), 32'(m_ram_data));
      end
      if (m_spch_we) begin
        chk("m_spch_addr", 32'(spch_addr), 32'(m_spch_addr));
        chk("m_spch_data", 32'(spch_data), 32'(m_spch_data));
      end
      if (m_out) begin
        chk("m_sdr_addr", 32'(sdr_addr), 32'(m_sdr_addr));
        chk("m_sdr_data", 32'(sdr_data), 32'(m_sdr_data));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    dl.dl_wr_i   = 1'b1;
    dl.dl_addr_i = a;
    dl.dl_data_i = d;
    tick();
    dl.dl_wr_i   = 1'b0;
  endtask

  task automatic ack();
    sdr_ack = 1'b1;
    tick();
    sdr_ack = 1'b0;
  endtask

  // Counts cycles from the cycle after the last reload until sys_reset is low.
  task automatic measure_fall(output int k);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!sys_reset) begin
        k = i;
        break;
      end
    end
  endtask

  int k;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    dl.dl_active_i = 1'b0;
    dl.dl_index_i  = 8'd0;
    dl.dl_wr_i     = 1'b0;
    dl.dl_addr_i   = '0;
    dl.dl_data_i   = '0;

    repeat (2) @(negedge clk);
    chk("rst_sys_reset", 32'(sys_reset), 32'd1);
    chk("rst_loading",   32'(loading),   32'd0);
    chk("rst_sdr_req",   32'(sdr_req),   32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    repeat (10) tick();
    @(negedge clk);
    chk("init_holds_reset", 32'(sys_reset), 32'd1);

    // Index 1 load
    tick();
    dl.dl_index_i  = 8'd1;
    dl.dl_active_i = 1'b1;
    tick(); tick();
    send(25'h0000004, 8'h5A);
    @(negedge clk);
    chk("c_ram_we",   32'(ram_we),   32'd1);
    chk("c_ram_addr", 32'(ram_addr), 32'h00005);
    chk("c_ram_data", 32'(ram_data), 32'h5A);
    chk("c_sdr_addr", 32'(sdr_addr), 32'h00004);
    tick();
    tick();
    sdr_ack = 1'b1;
    @(negedge clk);
    chk("wait_before_ack", 32'(dl.dl_wait_o), 32'd1);
    tick();
    sdr_ack = 1'b0;
    @(negedge clk);
    chk("wait_after_ack", 32'(dl.dl_wait_o), 32'd0);

    tick();
    send(25'h0000008, 8'h11);
    ack();
    @(negedge clk);
    chk("coincident_ack_wait", 32'(dl.dl_wait_o), 32'd0);
    send(25'h0040123, 8'h77);
    @(negedge clk);
    chk("spch_we",      32'(spch_we),   32'd1);
    chk("spch_addr",    32'(spch_addr), 32'h0123);
    chk("spch_no_ram",  32'(ram_we),    32'd0);
    chk("spch_sdr_req", 32'(sdr_req),   32'd1);
    ack();

    dl.dl_active_i = 1'b0;
    measure_fall(k);
    chk("fall_after_load", 32'(k), 32'd5);
    chk("rom_mask_idx1", 32'(rom_mask), 32'd0);

    // Index 3 load
    repeat (3) tick();
    dl.dl_index_i  = 8'd3;
    dl.dl_active_i = 1'b1;
    tick();
    send(25'h0000002, 8'hA5);
    @(negedge clk);
    chk("g_ram_addr", 32'(ram_addr), 32'h16003);
    ack();
    dl.dl_active_i = 1'b0;
    repeat (8) tick();

    // Index 2 load with overflow and reset-request overlap
    dl.dl_index_i  = 8'd2;
    dl.dl_active_i = 1'b1;
    tick();
    send(25'h0000011, 8'h3C);
    @(negedge clk);
    chk("d_ram_addr", 32'(ram_addr), 32'h02010);
    send(25'h0000012, 8'hC3);
    @(negedge clk);
    chk("ovf_no_second_we", 32'(ram_we), 32'd0);
    chk("ovf_set",          32'(ovf),    32'd1);
    ack();
    repeat (3) tick();
    @(negedge clk);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    rst_req = 1'b1;
    send(25'h0000020, 8'h99);
    rst_req = 1'b0;
    @(negedge clk);
    chk("rstreq_write_we",   32'(ram_we),   32'd1);
    chk("rstreq_write_addr", 32'(ram_addr), 32'h02021);
    ack();

    dl.dl_active_i = 1'b0;
    tick();
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    measure_fall(k);
    chk("fall_after_rst_req", 32'(k), 32'd5);
    chk("rom_mask_idx2", 32'(rom_mask), 32'd1);

    // Reset mid-transaction
    repeat (3) tick();
    dl.dl_index_i  = 8'd1;
    dl.dl_active_i = 1'b1;
    tick();
    send(25'h0000030, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_sdr_req", 32'(sdr_req),       32'd0);
    chk("abort_wait",    32'(dl.dl_wait_o),  32'd0);
    chk("abort_we",      32'(ram_we),        32'd0);
    chk("abort_ovf_clr", 32'(ovf),           32'd0);
    chk("abort_sys",     32'(sys_reset),     32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    dl.dl_active_i = 1'b0;
    measure_fall(k);
    chk("fall_after_reload_post_reset", 32'(k), 32'd5);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
